pt2272_vt_controller: RTL and testbench
=======================================

// Module: pt2272_vt_controller
// PURPOSE
//  Sequences frame acceptance downstream of the PT2272 frame decoder.
//  Qualifies decoded frames and raises VT (dv) only after CONFIRM_FRAMES consecutive identical, address-matched frames.
//  Holds dv and D while frames keep arriving; drops them after a HOLD_TICKS silence timeout on the 12 kHz oscillator tick.
//  Sits between the frame decoder outputs and the top-level D/dv pins.
// PARAMETERS
//  CONFIRM_FRAMES  2     identical matched frames required before dv rises (>=1)
//  HOLD_TICKS      1024  osc ticks without a good frame before dv drops (>=2; about 2.5 frames of 416 ticks)
// PORTS
//  clk         in   1  system clock, 3 MHz; single clock domain
//  reset       in   1  synchronous, active-high reset
//  tick        in   1  one-clk enable strobe at 12 kHz (clk/250)
//  frame_stb   in   1  one-clk pulse: decoder completed a frame (sync received)
//  frame_data  in   4  decoded data nibble; valid only when frame_stb=1
//  addr_ok     in   1  frame address matched A[7:0]; valid only when frame_stb=1
//  D           out  4  accepted data nibble
//  dv          out  1  valid transmission (VT)
//  new_stb     out  1  one-clk pulse on every IDLE/CONFIRM->VALID transition
//  err_cnt     out  8  count of address-mismatch frames; saturates at 255
// BEHAVIOUR
//  Reset (sync): state=IDLE, D=0, dv=0, new_stb=0, err_cnt=0, cand=0, match_cnt=0, hold_cnt=0.
//  Good frame = frame_stb & addr_ok. Bad frame = frame_stb & !addr_ok.
//  All outputs are registered: the cycle after a frame_stb shows its effect.
//  Timeout: a tick with no frame_stb increments hold_cnt.
//    Expiry occurs when hold_cnt==HOLD_TICKS-1 and tick=1.
//    Only good frames clear hold_cnt.
//  Simultaneous frame_stb and tick: the frame wins. The tick is discarded that cycle.
//  Bad frame: err_cnt+1 (saturating) in every state; any further action is per state below.
//  IDLE (dv=0)
//    Good frame: cand<=frame_data, match_cnt<=1, hold_cnt<=0.
//      Goes to CONFIRM.
//      If CONFIRM_FRAMES==1, goes straight to VALID instead.
//  CONFIRM (dv=0)
//    Good frame with data==cand: match_cnt+1, hold_cnt<=0.
//      If match_cnt+1==CONFIRM_FRAMES: go to VALID, D<=cand, dv<=1, new_stb<=1.
//    Good frame with data!=cand: cand<=frame_data, match_cnt<=1. Stay in CONFIRM.
//    Bad frame: go to IDLE, match_cnt<=0.
//    Timeout expiry: go to IDLE.
//  VALID (dv=1)
//    Good frame with data==cand: hold_cnt<=0. D and dv unchanged. No new_stb.
//    Good frame with data!=cand: dv<=0, cand<=frame_data, match_cnt<=1. Go to CONFIRM.
//      If CONFIRM_FRAMES==1: stay in VALID, D<=frame_data, new_stb<=1.
//    Bad frame: no state change; the timeout keeps running.
//    Timeout expiry: dv<=0, go to IDLE.
//  Reset asserted mid-operation: next clk returns everything to reset values. Any in-flight confirmation is lost.
//  Counter widths: match_cnt is $clog2(CONFIRM_FRAMES+1); hold_cnt is $clog2(HOLD_TICKS). Neither counter wraps.
// CONFIGURATION
//  PT2272_LATCH_MODE_EN
//    Defined (L4 variant): D keeps its last accepted value whenever dv falls. D only changes on entry to VALID.
//    Undefined (M4 momentary, default): D<=0 in the same cycle dv falls. This applies to timeout, a data change and leaving VALID.
// STRUCTURE
//  pt2272_pkg
//    vt_state_t enum {VT_IDLE, VT_CONFIRM, VT_VALID}
//    PT2272_DATA_W=4
//    PT2272_FRAME_TICKS=416
//    PT2272_ERR_W=8
//  Sub-module pt2272_hold_timer
//    Inputs: clk, reset, tick, clr.
//    Output: expire, a one-clk pulse.
//    Parameter: HOLD_TICKS. clr has priority over tick.
//  The FSM, cand/match_cnt registers and err counter live in this module.
// TESTING
//  1. Two good frames data=4'hA, 416 ticks apart -> dv=1, D=4'hA one clk after the 2nd frame_stb; new_stb=1 for one clk.
//  2. Good 4'h3 then good 4'h5 -> stays CONFIRM with cand=4'h5, dv=0. A following good 4'h5 -> dv=1, D=4'h5.
//  3. VALID with D=4'hA, then 1024 ticks with no frame -> dv=0.
//     D=4'h0 without the macro; D stays 4'hA with PT2272_LATCH_MODE_EN.
//  4. VALID, then a good frame 4'hC -> dv=0 next clk. A second 4'hC -> dv=1, D=4'hC, one new_stb pulse.
//  5. 260 frames with addr_ok=0 -> err_cnt=255 (saturated), dv=0 throughout.
//     A bad frame in CONFIRM returns the FSM to IDLE.
//  6. Two events:
//     - frame_stb coincident with the 1024th tick -> no timeout, hold_cnt=0.
//     - reset pulse while in VALID -> D=0, dv=0, err_cnt=0 on the next clk.

Source files
------------

// File: rtl/pt2272_pkg.sv
// Shared types and constants for the PT2272 valid-transmission (VT) controller.
package pt2272_pkg;

  typedef enum logic [1:0] {
    VT_IDLE    = 2'd0,
    VT_CONFIRM = 2'd1,
    VT_VALID   = 2'd2
  } vt_state_t;

  localparam int unsigned PT2272_DATA_W      = 4;
  localparam int unsigned PT2272_FRAME_TICKS = 416;
  localparam int unsigned PT2272_ERR_W       = 8;

  function automatic logic [PT2272_ERR_W-1:0] sat_inc(input logic [PT2272_ERR_W-1:0] v);
    return (v == '1) ? v : v + PT2272_ERR_W'(1);
  endfunction

endpackage

// File: rtl/pt2272_hold_timer.sv
// Silence timer: counts osc ticks since the last good frame and pulses expire on the last one.
module pt2272_hold_timer #(
  parameter int unsigned HOLD_TICKS = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic clr,
  output logic expire
);

  localparam int unsigned CntW = $clog2(HOLD_TICKS);
  localparam logic [CntW-1:0] CntLast = CntW'(HOLD_TICKS - 1);

  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    expire     = 1'b0;
    if (clr) begin
      hold_cnt_d = '0;
    end else if (tick) begin
      if (hold_cnt_q == CntLast) begin
        // Restart rather than wrap so the counter never overflows.
        hold_cnt_d = '0;
        expire     = 1'b1;
      end else begin
        hold_cnt_d = hold_cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

endmodule

// File: rtl/pt2272_vt_controller.sv
// Frame qualification FSM driving the PT2272 D/VT outputs.
// Define PT2272_LATCH_MODE_EN for the latching (L4) variant; default is momentary (M4).
module pt2272_vt_controller
  import pt2272_pkg::*;
#(
  parameter int unsigned CONFIRM_FRAMES = 2,
  parameter int unsigned HOLD_TICKS     = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     frame_stb,
  input  logic [PT2272_DATA_W-1:0] frame_data,
  input  logic                     addr_ok,
  output logic [PT2272_DATA_W-1:0] D,
  output logic                     dv,
  output logic                     new_stb,
  output logic [PT2272_ERR_W-1:0]  err_cnt
);

  localparam int unsigned MatchW = $clog2(CONFIRM_FRAMES + 1);
  localparam logic [MatchW-1:0] MatchTarget = MatchW'(CONFIRM_FRAMES);
  localparam logic [MatchW-1:0] MatchOne    = MatchW'(1);

  vt_state_t                state_q, state_d;
  logic [PT2272_DATA_W-1:0] cand_q, cand_d;
  logic [MatchW-1:0]        match_cnt_q, match_cnt_d;
  logic [PT2272_DATA_W-1:0] d_q, d_d, d_drop;
  logic                     dv_q, dv_d;
  logic                     new_stb_q, new_stb_d;
  logic [PT2272_ERR_W-1:0]  err_cnt_q, err_cnt_d;

  logic good_frame, bad_frame, tick_eff, expire;

  assign good_frame = frame_stb & addr_ok;
  assign bad_frame  = frame_stb & ~addr_ok;
  // A frame in the same cycle as a tick swallows the tick.
  assign tick_eff   = tick & ~frame_stb;

  pt2272_hold_timer #(
    .HOLD_TICKS(HOLD_TICKS)
  ) u_hold_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_eff),
    .clr   (good_frame),
    .expire(expire)
  );

`ifdef PT2272_LATCH_MODE_EN
  assign d_drop = d_q;
`else
  assign d_drop = '0;
`endif

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    match_cnt_d = match_cnt_q;
    d_d         = d_q;
    dv_d        = dv_q;
    new_stb_d   = 1'b0;
    err_cnt_d   = bad_frame ? sat_inc(err_cnt_q) : err_cnt_q;

    unique case (state_q)
      VT_IDLE: begin
        if (good_frame) begin
          cand_d      = frame_data;
          match_cnt_d = MatchOne;
          if (CONFIRM_FRAMES == 1) begin
            state_d   = VT_VALID;
            d_d       = frame_data;
            dv_d      = 1'b1;
            new_stb_d = 1'b1;
          end else begin
            state_d = VT_CONFIRM;
          end
        end
      end
      VT_CONFIRM: begin
        if (good_frame) begin
          if (frame_data == cand_q) begin
            match_cnt_d = match_cnt_q + MatchOne;
            if (match_cnt_d == MatchTarget) begin
              state_d   = VT_VALID;
              d_d       = cand_q;
              dv_d      = 1'b1;
              new_stb_d = 1'b1;
            end
          end else begin
            cand_d      = frame_data;
            match_cnt_d = MatchOne;
          end
        end else if (bad_frame || expire) begin
          state_d     = VT_IDLE;
          match_cnt_d = '0;
        end
      end
      VT_VALID: begin
        if (good_frame && (frame_data != cand_q)) begin
          cand_d      = frame_data;
          match_cnt_d = MatchOne;
          if (CONFIRM_FRAMES == 1) begin
            d_d       = frame_data;
            new_stb_d = 1'b1;
          end else begin
            state_d = VT_CONFIRM;
            dv_d    = 1'b0;
            d_d     = d_drop;
          end
        end else if (expire) begin
          state_d     = VT_IDLE;
          match_cnt_d = '0;
          dv_d        = 1'b0;
          d_d         = d_drop;
        end
      end
      default: begin
        state_d     = VT_IDLE;
        match_cnt_d = '0;
        dv_d        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= VT_IDLE;
      cand_q      <= '0;
      match_cnt_q <= '0;
      d_q         <= '0;
      dv_q        <= 1'b0;
      new_stb_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      match_cnt_q <= match_cnt_d;
      d_q         <= d_d;
      dv_q        <= dv_d;
      new_stb_q   <= new_stb_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign D       = d_q;
  assign dv      = dv_q;
  assign new_stb = new_stb_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_pt2272_vt_controller.sv
// Directed self-checking bench for pt2272_vt_controller (honours PT2272_LATCH_MODE_EN).
module tb_pt2272_vt_controller;
  import pt2272_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       frame_stb = 1'b0;
  logic [3:0] frame_data = 4'h0;
  logic       addr_ok = 1'b0;
  logic [3:0] D;
  logic       dv;
  logic       new_stb;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;

  pt2272_vt_controller #(
    .CONFIRM_FRAMES(2),
    .HOLD_TICKS    (1024)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .frame_stb (frame_stb),
    .frame_data(frame_data),
    .addr_ok   (addr_ok),
    .D         (D),
    .dv        (dv),
    .new_stb   (new_stb),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs; returns at the following negedge with inputs cleared.
  task automatic cyc(input logic stb, input logic [3:0] data, input logic ok, input logic tk);
    @(negedge clk);
    frame_stb  = stb;
    frame_data = data;
    addr_ok    = ok;
    tick       = tk;
    @(negedge clk);
    frame_stb  = 1'b0;
    frame_data = 4'h0;
    addr_ok    = 1'b0;
    tick       = 1'b0;
  endtask

  task automatic frame(input logic [3:0] data, input logic ok);
    cyc(1'b1, data, ok, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 4'h0, 1'b0, 1'b1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [3:0] drop_a, drop_5;

  initial begin
`ifdef PT2272_LATCH_MODE_EN
    drop_a = 4'hA;
    drop_5 = 4'h5;
`else
    drop_a = 4'h0;
    drop_5 = 4'h0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_D", {4'h0, D}, 8'h00);
    chk("reset_dv", {7'd0, dv}, 8'd0);
    chk("reset_new_stb", {7'd0, new_stb}, 8'd0);
    chk("reset_err_cnt", err_cnt, 8'd0);

    // Two identical frames one frame period apart
    frame(4'hA, 1'b1);
    chk("t1_first_dv", {7'd0, dv}, 8'd0);
    chk("t1_first_new_stb", {7'd0, new_stb}, 8'd0);
    ticks(PT2272_FRAME_TICKS);
    frame(4'hA, 1'b1);
    chk("t1_dv", {7'd0, dv}, 8'd1);
    chk("t1_D", {4'h0, D}, 8'h0A);
    chk("t1_new_stb", {7'd0, new_stb}, 8'd1);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    chk("t1_new_stb_pulse", {7'd0, new_stb}, 8'd0);

    // Silence timeout
    ticks(1023);
    chk("t3_dv_before_expiry", {7'd0, dv}, 8'd1);
    ticks(1);
    chk("t3_dv_expired", {7'd0, dv}, 8'd0);
    chk("t3_D_expired", {4'h0, D}, {4'h0, drop_a});

    // Candidate replacement in CONFIRM
    frame(4'h3, 1'b1);
    frame(4'h5, 1'b1);
    chk("t2_dv_after_change", {7'd0, dv}, 8'd0);
    frame(4'h5, 1'b1);
    chk("t2_dv", {7'd0, dv}, 8'd1);
    chk("t2_D", {4'h0, D}, 8'h05);
    chk("t2_new_stb", {7'd0, new_stb}, 8'd1);

    // Data change while VALID
    frame(4'hC, 1'b1);
    chk("t4_dv_drop", {7'd0, dv}, 8'd0);
    chk("t4_D_drop", {4'h0, D}, {4'h0, drop_5});
    chk("t4_no_new_stb", {7'd0, new_stb}, 8'd0);
    frame(4'hC, 1'b1);
    chk("t4_dv", {7'd0, dv}, 8'd1);
    chk("t4_D", {4'h0, D}, 8'h0C);
    chk("t4_new_stb", {7'd0, new_stb}, 8'd1);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    chk("t4_new_stb_pulse", {7'd0, new_stb}, 8'd0);

    // Repeat of accepted data: no new pulse
    frame(4'hC, 1'b1);
    chk("valid_repeat_new_stb", {7'd0, new_stb}, 8'd0);
    chk("valid_repeat_dv", {7'd0, dv}, 8'd1);

    // Bad frame in VALID only counts
    frame(4'h1, 1'b0);
    chk("valid_bad_dv", {7'd0, dv}, 8'd1);
    chk("valid_bad_err", err_cnt, 8'd1);

    // Frame coincident with the 1024th tick wins and restarts the timer
    ticks(1023);
    cyc(1'b1, 4'hC, 1'b1, 1'b1);
    chk("t6_coincident_dv", {7'd0, dv}, 8'd1);
    ticks(1023);
    chk("t6_still_valid", {7'd0, dv}, 8'd1);
    ticks(1);
    chk("t6_expired", {7'd0, dv}, 8'd0);

    // Bad frame in CONFIRM returns to IDLE
    frame(4'h7, 1'b1);
    frame(4'h7, 1'b0);
    chk("t5_confirm_bad_err", err_cnt, 8'd2);
    frame(4'h7, 1'b1);
    chk("t5_restart_dv", {7'd0, dv}, 8'd0);
    frame(4'h7, 1'b1);
    chk("t5_confirm_dv", {7'd0, dv}, 8'd1);
    chk("t5_confirm_D", {4'h0, D}, 8'h07);

    // Reset while VALID
    do_reset();
    chk("t6_reset_D", {4'h0, D}, 8'h00);
    chk("t6_reset_dv", {7'd0, dv}, 8'd0);
    chk("t6_reset_err", err_cnt, 8'd0);

    // Error counter saturation
    for (int i = 0; i < 260; i++) begin
      frame(4'h9, 1'b0);
      if (dv !== 1'b0) begin
        chk("t5_sat_dv", {7'd0, dv}, 8'd0);
      end
      if (i == 253) begin
        chk("t5_err_254", err_cnt, 8'd254);
      end
    end
    chk("t5_err_sat", err_cnt, 8'd255);
    chk("t5_sat_dv_end", {7'd0, dv}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
